// File: rtl/shift_reg_pkg.sv
// Shared mode codes and FSM state encoding for the shift-register sequencer.
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StLoad  = 2'b01,
    StShift = 2'b10,
    StDone  = 2'b11
  } state_e;

endpackage

// File: rtl/shift_reg_ctrl_if.sv
// Host-side bundle of the sequencer: word handshake, abort and observed register state.
interface shift_reg_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] data_in;
  logic             dir;
  logic             abort;
  logic [1:0]       mode;
  logic [WIDTH-1:0] q;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output start_valid, data_in, dir, abort,
    input  start_ready, mode, q, serial_out, busy, done
  );

  modport slave (
    input  start_valid, data_in, dir, abort,
    output start_ready, mode, q, serial_out, busy, done
  );
endinterface

// File: rtl/shift_reg_universal.sv
// WIDTH-bit universal shift register: hold, shift right, shift left or parallel load.
module shift_reg_universal
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      unique case (mode)
        MODE_HOLD: q <= q;
        MODE_SHR:  q <= {ser_in, q[WIDTH-1:1]};
        MODE_SHL:  q <= {q[WIDTH-2:0], ser_in};
        MODE_LOAD: q <= d;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/shift_reg_ctrl.sv
// Self-timed parallel-to-serial sequencer around a universal shift register.
// Build option SHIFT_REG_CTRL_CIRC_EN: rotate instead of zero-fill during SHIFT.
module shift_reg_ctrl
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic              clk,
  input logic              reset,
  shift_reg_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] word;
  logic             dir_cap;
  logic [1:0]       mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic             exit_bit;
  logic             ser_in;

  assign exit_bit = dir_cap ? q[0] : q[WIDTH-1];

`ifdef SHIFT_REG_CTRL_CIRC_EN
  assign ser_in = exit_bit;
`else
  assign ser_in = 1'b0;
`endif

  assign bus.start_ready = (state == StIdle) && !bus.abort;
  assign bus.serial_out  = (state == StShift) && exit_bit;
  assign bus.mode        = mode;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.q           = q;

  // Mode is registered alongside the state so the datapath acts on the mode shown this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= StIdle;
      cnt     <= '0;
      word    <= '0;
      dir_cap <= 1'b0;
      mode    <= MODE_HOLD;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.start_valid && bus.start_ready) begin
            word    <= bus.data_in;
            dir_cap <= bus.dir;
            state   <= StLoad;
            mode    <= MODE_LOAD;
            busy    <= 1'b1;
          end
        end
        StLoad: begin
          if (bus.abort) begin
            state <= StIdle;
            mode  <= MODE_HOLD;
            busy  <= 1'b0;
          end else begin
            cnt   <= '0;
            state <= StShift;
            mode  <= dir_cap ? MODE_SHR : MODE_SHL;
          end
        end
        StShift: begin
          if (bus.abort) begin
            state <= StIdle;
            mode  <= MODE_HOLD;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state <= StDone;
              mode  <= MODE_HOLD;
              done  <= 1'b1;
            end
          end
        end
        StDone: begin
          state <= StIdle;
          mode  <= MODE_HOLD;
          busy  <= 1'b0;
        end
        default: begin
          state <= StIdle;
          mode  <= MODE_HOLD;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  shift_reg_universal #(
    .WIDTH (WIDTH)
  ) u_reg (
    .clk    (clk),
    .reset  (reset),
    .mode   (mode),
    .d      (word),
    .ser_in (ser_in),
    .q      (q)
  );

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Randomised bench for shift_reg_ctrl against a per-transfer arithmetic model.
module tb_shift_reg_ctrl;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_reg_ctrl_if #(.WIDTH(W)) bus ();

  shift_reg_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] model_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {start_ready, busy, done, serial_out, mode, q}
  function automatic logic [31:0] pack(input logic r, input logic b, input logic dn,
                                       input logic s, input logic [1:0] m,
                                       input logic [W-1:0] qv);
    return 32'({r, b, dn, s, m, qv});
  endfunction

  function automatic logic [31:0] observe();
    return pack(bus.start_ready, bus.busy, bus.done, bus.serial_out, bus.mode, bus.q);
  endfunction

  // Register contents after n shifts of word w in direction d.
  function automatic logic [W-1:0] shifted(input logic [W-1:0] w, input logic d, input int n);
    logic [2*W-1:0] wide;
    logic [W-1:0]   r;
    wide = {w, w};
`ifdef SHIFT_REG_CTRL_CIRC_EN
    if (d) begin
      wide = wide >> n;
      r = wide[W-1:0];
    end else begin
      wide = wide << n;
      r = wide[2*W-1:W];
    end
`else
    r = w;
    if (d) r = r >> n;
    else   r = r << n;
`endif
    return r;
  endfunction

  // Starts at a negedge in IDLE; ends at a negedge in IDLE.
  task automatic xfer(input logic [W-1:0] word, input logic d, input int abort_at, input bit hold);
    logic [31:0] exp;
    int          n;
    bus.start_valid = 1'b1;
    bus.data_in     = word;
    bus.dir         = d;
    bus.abort       = 1'b0;
    #1 check("idle_pre", observe(), pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, model_q));
    @(posedge clk);
    #1;
    bus.start_valid = hold;
    bus.data_in     = W'($urandom);
    bus.dir         = 1'($urandom);
    for (int c = 1; c <= int'(W) + 2; c++) begin
      @(negedge clk);
      if (c == 1) begin
        exp = pack(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, model_q);
      end else if (c <= int'(W) + 1) begin
        n   = c - 2;
        exp = pack(1'b0, 1'b1, 1'b0, d ? word[n] : word[int'(W) - 1 - n],
                   d ? 2'b01 : 2'b10, shifted(word, d, n));
      end else begin
        exp = pack(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, shifted(word, d, W));
      end
      check($sformatf("cyc%0d_w%h_d%0d", c, word, d), observe(), exp);
      if (c == abort_at) begin
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort       = 1'b0;
        bus.start_valid = 1'b0;
        model_q = shifted(word, d, (c - 1 < int'(W)) ? c - 1 : int'(W));
        repeat (2) begin
          @(negedge clk);
          check($sformatf("abort%0d_frozen", c), observe(),
                pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, model_q));
        end
        return;
      end
    end
    model_q = shifted(word, d, W);
    @(negedge clk);
    check("post_idle", observe(), pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, model_q));
  endtask

  initial begin
    int          ab;
    logic [W-1:0] w;
    logic        d;
    reset           = 1'b1;
    bus.start_valid = 1'b0;
    bus.data_in     = '0;
    bus.dir         = 1'b0;
    bus.abort       = 1'b0;
    model_q         = '0;
    #1 check("reset_vals", observe(), pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, '0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    xfer(4'b1011, 1'b1, -1, 1'b0);
    xfer(4'b1011, 1'b0, -1, 1'b0);
    xfer(4'b1100, 1'b0, -1, 1'b1);
    xfer(4'b0011, 1'b1, -1, 1'b0);
    xfer(4'b1011, 1'b1, 3, 1'b0);

    // Asynchronous reset mid-SHIFT, checked before the next rising edge.
    bus.start_valid = 1'b1;
    bus.data_in     = 4'b1011;
    bus.dir         = 1'b1;
    @(posedge clk);
    #1 bus.start_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1 check("reset_async", observe(), pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, '0));
    @(negedge clk);
    reset   = 1'b0;
    model_q = '0;
    @(negedge clk);
    check("after_reset", observe(), pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, '0));

    for (int i = 0; i < 60; i++) begin
      w  = W'($urandom);
      d  = 1'($urandom);
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(1, W + 2)) : -1;
      xfer(w, d, ab, 1'($urandom_range(1)));
    end

    // Abort in IDLE must block the handshake.
    bus.abort       = 1'b1;
    bus.start_valid = 1'b1;
    bus.data_in     = 4'b0110;
    #1 check("idle_abort_ready", observe(), pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, model_q));
    repeat (3) begin
      @(negedge clk);
      check("idle_abort_hold", observe(), pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, model_q));
    end
    bus.abort       = 1'b0;
    bus.start_valid = 1'b0;
    @(negedge clk);
    check("idle_abort_end", observe(), pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, model_q));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_reg_ctrl.md
Name: shift_reg_ctrl

Overview:
Sequencer for a WIDTH-bit universal shift register. Accepts a parallel word over a valid/ready handshake and loads it. Shifts it out serially, MSB-first or LSB-first, then pulses done. Sits between a host and the serial link; makes the shift-register datapath a self-timed parallel-to-serial unit.

Parameters:
WIDTH, 4, data word width in bits (>= 2)
CNT_W, $clog2(WIDTH)+1, localparam; width of the shift counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start_valid  input  1  host offers a word
start_ready  output  1  controller can accept a word
data_in  input  WIDTH  word to serialise; sampled on the handshake edge
dir  input  1  0 = shift left (MSB first), 1 = shift right (LSB first); sampled on the handshake edge
abort  input  1  cancel the transfer in progress
mode  output  2  register mode: 00 hold, 01 shift right, 10 shift left, 11 load
q  output  WIDTH  current shift-register contents
serial_out  output  1  bit being shifted out this cycle
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a transfer completes

Behaviour:
- Reset (async, active-high), output values while reset is asserted and after release:
  - state=IDLE, q=0, counter=0, captured word and dir = 0
  - mode=00, busy=0, done=0, serial_out=0
  - start_ready=1 when abort=0
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start_ready = !abort
  - Handshake = start_valid && start_ready at a rising edge. On that edge, capture data_in and dir, then go to LOAD.
  - mode=00; q holds its value.
- LOAD (1 cycle):
  - mode=11; start_ready=0.
  - q takes the captured word at the next edge; counter cleared to 0.
  - Next state: SHIFT.
- SHIFT (exactly WIDTH cycles):
  - mode = 01 if dir=1, 10 if dir=0.
  - serial_out = q[0] when dir=1, q[WIDTH-1] when dir=0.
  - Vacated bit filled with 0.
  - Counter increments each edge. Leave for DONE on the edge where counter == WIDTH-1.
- DONE (1 cycle): done=1, mode=00, then IDLE.
- serial_out:
  - Combinational from q and the captured dir.
  - Valid only in SHIFT; forced to 0 in all other states.
- Latency:
  - Handshake at edge 0; loaded word visible on q after edge 1.
  - Bit k (k = 0..WIDTH-1) on serial_out during cycle 2+k.
  - done high during cycle WIDTH+2.
  - Next handshake possible at edge WIDTH+3.
- Back-to-back transfers: start_valid held high is accepted on the first IDLE edge. No bubble beyond the single IDLE cycle.
- abort:
  - In LOAD, SHIFT or DONE: next edge goes to IDLE, mode=00, q frozen at its current value, no done pulse.
  - In IDLE: blocks the handshake (start_ready=0). Otherwise no effect.
- data_in and dir changes outside the handshake edge have no effect on a transfer in progress.
- Reset mid-transfer: immediate return to reset values; the partial word is lost.

Optional Feature:
SHIFT_REG_CTRL_CIRC_EN:
- Defined: SHIFT rotates, so the vacated bit takes the bit being shifted out. After WIDTH shifts q equals the loaded word again, and q is held through DONE.
- Undefined: zeros are shifted in; q = 0 at DONE after a full transfer.

Decomposition:
- Package shift_reg_pkg holds:
  - mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11
  - FSM state encoding
- Sub-module shift_reg_universal (clk, reset, mode, d, ser_in, q): the datapath register. The controller drives mode and ser_in; ser_in = 0, or the exiting bit under SHIFT_REG_CTRL_CIRC_EN.

Test Plan (WIDTH=4):
- Reset asserted mid-SHIFT → q=0000, busy=0, mode=00, start_ready=1 immediately (async), before the next clk edge.
- data_in=4'b1011, dir=1 → serial_out 1,1,0,1 over cycles 2-5; q 1011→0101→0010→0001→0000; done high for exactly cycle 6.
- data_in=4'b1011, dir=0 → serial_out 1,0,1,1; q 1011→0110→1100→1000→0000; done once.
- start_valid held high with 4'b1100 then 4'b0011 → second handshake at edge 7; no missed or duplicated bits; data_in changes mid-SHIFT ignored.
- abort asserted in second SHIFT cycle of 1011, dir=1 → next state IDLE, q frozen at 0010, done never pulses; abort with start_valid in IDLE → no handshake.
- SHIFT_REG_CTRL_CIRC_EN defined, 4'b1011, dir=1 → serial_out 1,1,0,1; q 1101→1110→0111→1011; q=1011 at done.
